gp_timer: RTL and testbench

- Parametrised multi-channel general-purpose timer peripheral for the RV32I microcontroller. Successor to the fixed single TIM_PSC/TIM_ARR pair.
- Adds:
  - preloaded (shadowed) prescaler and auto-reload registers;
  - NUM_CH compare/PWM channels;
  - sticky event flags with interrupt masking.
- Programmed over a simple word-addressed register write/read port driven by the core's timer instructions.

---
 rtl/gp_timer_pkg.sv | 24 ++
 rtl/gp_timer_prescaler.sv | 33 +++
 rtl/gp_timer.sv | 154 +++++++++++++++
 tb/tb_gp_timer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_timer_pkg.sv
// gp_timer shared definitions: register indices, CTRL/STATUS bit positions, CTRL layout.
package gp_timer_pkg;

   localparam logic [3:0] ADDR_CTRL   = 4'd0;
   localparam logic [3:0] ADDR_STATUS = 4'd1;
   localparam logic [3:0] ADDR_IER    = 4'd2;
   localparam logic [3:0] ADDR_PSC    = 4'd3;
   localparam logic [3:0] ADDR_ARR    = 4'd4;
   localparam logic [3:0] ADDR_CNT    = 4'd5;
   localparam logic [3:0] ADDR_EGR    = 4'd6;
   localparam logic [3:0] ADDR_CCR0   = 4'd8;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_OPM_BIT   = 1;
   localparam int STATUS_UIF_BIT = 0;
   localparam int STATUS_CC0_BIT = 1;
   localparam int EGR_UG_BIT     = 0;

   typedef struct packed {
      logic opm;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/gp_timer_prescaler.sv
// Prescaler for gp_timer: holds the active PSC shadow and produces one tick every PSC_act+1 enabled cycles.
module gp_timer_prescaler #(
   parameter int PSC_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic             load,
   input  logic [PSC_W-1:0] psc_pre,
   output logic             tick
);

   logic [PSC_W-1:0] psc_cnt;
   logic [PSC_W-1:0] psc_act;

   assign tick = en && (psc_cnt == psc_act);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc_cnt <= '0;
         psc_act <= '0;
      end else begin
         if (load)
            psc_act <= psc_pre;
         if (clear || tick)
            psc_cnt <= '0;
         else if (en)
            psc_cnt <= psc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gp_timer.sv
// Multi-channel general-purpose timer with shadowed PSC/ARR, compare/PWM channels and sticky flags.
// Build option GPTIM_ONE_PULSE_EN implements CTRL.OPM (stop after one counter period).
module gp_timer
   import gp_timer_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int PSC_W  = 16,
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_we,
   input  logic [3:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic [CNT_W-1:0]  cnt,
   output logic [NUM_CH-1:0] cmp_out,
   output logic              update_evt,
   output logic              irq
);

   ctrl_t                         ctrl;
   logic [NUM_CH:0]               status;
   logic [NUM_CH:0]               status_nxt;
   logic [NUM_CH:0]               ier;
   logic [NUM_CH-1:0]             cc_set;
   logic [PSC_W-1:0]              psc_pre;
   logic [CNT_W-1:0]              arr_pre;
   logic [CNT_W-1:0]              arr_act;
   logic [CNT_W-1:0]              cnt_step;
   logic [NUM_CH-1:0][CNT_W-1:0]  ccr;
   logic wr_ctrl, wr_status, wr_ier, wr_psc, wr_arr, wr_cnt, ug;
   logic tick, eff_tick, at_top, wrap, upd;
   logic unused_wdata;

   assign wr_ctrl   = reg_we && (reg_addr == ADDR_CTRL);
   assign wr_status = reg_we && (reg_addr == ADDR_STATUS);
   assign wr_ier    = reg_we && (reg_addr == ADDR_IER);
   assign wr_psc    = reg_we && (reg_addr == ADDR_PSC);
   assign wr_arr    = reg_we && (reg_addr == ADDR_ARR);
   assign wr_cnt    = reg_we && (reg_addr == ADDR_CNT);
   assign ug        = reg_we && (reg_addr == ADDR_EGR) && reg_wdata[EGR_UG_BIT];
   assign unused_wdata = ^reg_wdata;

   // A CNT write swallows the tick: no count, no compare flag, no update event.
   assign eff_tick = tick && !wr_cnt;
   assign at_top   = (cnt == arr_act);
   assign wrap     = eff_tick && at_top;
   assign upd      = wrap || ug;
   assign cnt_step = at_top ? '0 : cnt + 1'b1;

   gp_timer_prescaler #(.PSC_W(PSC_W)) u_psc (
      .clk     (clk),
      .reset   (reset),
      .en      (ctrl.en),
      .clear   (ug || wr_cnt),
      .load    (upd),
      .psc_pre (psc_pre),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         psc_pre    <= '0;
         arr_pre    <= '1;
         arr_act    <= '1;
         ier        <= '0;
         status     <= '0;
         update_evt <= 1'b0;
      end else begin
         if (wr_cnt)
            cnt <= reg_wdata[CNT_W-1:0];
         else if (ug)
            cnt <= '0;
         else if (eff_tick)
            cnt <= cnt_step;
         if (wr_psc)
            psc_pre <= reg_wdata[PSC_W-1:0];
         if (wr_arr)
            arr_pre <= reg_wdata[CNT_W-1:0];
         if (upd)
            arr_act <= arr_pre;
         if (wr_ier)
            ier <= reg_wdata[NUM_CH:0];
         status     <= status_nxt;
         update_evt <= upd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl <= '0;
      end else if (wr_ctrl) begin
         ctrl.en <= reg_wdata[CTRL_EN_BIT];
`ifdef GPTIM_ONE_PULSE_EN
         ctrl.opm <= reg_wdata[CTRL_OPM_BIT];
      end else if (wrap && ctrl.opm) begin
         ctrl.en <= 1'b0;
`endif
      end
   end

   // Hardware set beats a simultaneous write-1-to-clear.
   always_comb begin
      status_nxt = status;
      if (wr_status)
         status_nxt = status & ~reg_wdata[NUM_CH:0];
      status_nxt = status_nxt | {cc_set, upd};
   end

   assign irq = |(status & ier);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             wr_ccr;
      logic [CNT_W-1:0] ccr_q;
      logic             cmp_q;

      assign wr_ccr    = reg_we && (reg_addr == ADDR_CCR0 + 4'(i));
      assign ccr[i]    = ccr_q;
      assign cmp_out[i] = cmp_q;
      assign cc_set[i] = eff_tick && (cnt_step == ccr_q);

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            ccr_q <= '0;
            cmp_q <= 1'b0;
         end else begin
            if (wr_ccr)
               ccr_q <= reg_wdata[CNT_W-1:0];
            if (ctrl.en)
               cmp_q <= (cnt < ccr_q);
         end
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         ADDR_CTRL:   reg_rdata[1:0]        = ctrl;
         ADDR_STATUS: reg_rdata[NUM_CH:0]   = status;
         ADDR_IER:    reg_rdata[NUM_CH:0]   = ier;
         ADDR_PSC:    reg_rdata[PSC_W-1:0]  = psc_pre;
         ADDR_ARR:    reg_rdata[CNT_W-1:0]  = arr_pre;
         ADDR_CNT:    reg_rdata[CNT_W-1:0]  = cnt;
         default: begin
            for (int i = 0; i < NUM_CH; i++)
               if (reg_addr == ADDR_CCR0 + 4'(i))
                  reg_rdata[CNT_W-1:0] = ccr[i];
         end
      endcase
   end

endmodule

// File: tb/tb_gp_timer.sv
// Scoreboard bench for gp_timer: stimulus queues expected values, a negedge monitor compares them.
module tb_gp_timer;

   localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_IER = 4'd2, A_PSC = 4'd3;
   localparam logic [3:0] A_ARR = 4'd4, A_CNT = 4'd5, A_EGR = 4'd6, A_CCR0 = 4'd8;
   localparam int K_CNT = 0, K_RD = 1, K_CMP = 2, K_UEVT = 3, K_IRQ = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_we = 1'b0;
   logic [3:0]  reg_addr = 4'd0;
   logic [31:0] reg_wdata = 32'd0;
   logic [31:0] reg_rdata;
   logic [15:0] cnt;
   logic [3:0]  cmp_out;
   logic        update_evt;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   int          q_kind[$];
   logic [31:0] q_exp[$];
   string       q_name[$];

   int t3_cnt[10]  = '{1, 7, 8, 9, 0, 1, 9, 5, 6, 7};
   int t3_cmp[10]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
   int t3_uevt[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
   int t3_stat[10] = '{'h1D, 'h1D, 'h1C, 'h1C, 'h1D, 'h1D, 'h1D, 'h1D, 'h1D, 'h1D};

   gp_timer #(.CNT_W(16), .PSC_W(16), .NUM_CH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .reg_we     (reg_we),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .cnt        (cnt),
      .cmp_out    (cmp_out),
      .update_evt (update_evt),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (q_kind.size() > 0) begin
         int          k;
         logic [31:0] e;
         logic [31:0] a;
         string       nm;
         k  = q_kind.pop_front();
         e  = q_exp.pop_front();
         nm = q_name.pop_front();
         case (k)
            K_CNT:   a = 32'(cnt);
            K_RD:    a = reg_rdata;
            K_CMP:   a = 32'(cmp_out);
            K_UEVT:  a = 32'(update_evt);
            default: a = 32'(irq);
         endcase
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      reg_we = 1'b1;
      reg_addr = a;
      reg_wdata = d;
      @(posedge clk);
      #1;
      reg_we = 1'b0;
   endtask

   task automatic expo(input int k, input logic [31:0] e, input string nm);
      q_kind.push_back(k);
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   task automatic exprd(input logic [3:0] a, input logic [31:0] e, input string nm);
      reg_addr = a;
      expo(K_RD, e, nm);
   endtask

   task automatic sync();
      int n = 0;
      while (q_kind.size() != 0 && n < 20) begin
         #1;
         n++;
      end
      if (q_kind.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sync_timeout: got %0d pending, expected 0", q_kind.size());
         q_kind.delete();
         q_exp.delete();
         q_name.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);

      // reset state
      expo(K_CNT, 0, "rst_cnt");
      expo(K_CMP, 0, "rst_cmp");
      expo(K_UEVT, 0, "rst_uevt");
      expo(K_IRQ, 0, "rst_irq");
      exprd(A_ARR, 32'h0000FFFF, "rst_arr");
      sync();
      exprd(A_CTRL, 0, "rst_ctrl");
      sync();
      exprd(A_STATUS, 0, "rst_status");
      sync();

      // divide/wrap, then ARR preload mid-period
      wr(A_PSC, 2);
      wr(A_ARR, 4);
      wr(A_EGR, 1);
      wr(A_STATUS, 1);
      wr(A_CTRL, 1);
      for (int k = 1; k <= 63; k++) begin
         int base;
         if (k == 22) wr(A_ARR, 9);
         else step(1);
         base = (k >= 60) ? 60 : (k >= 30) ? 30 : (k >= 15) ? 15 : 0;
         expo(K_CNT, 32'((k - base) / 3), $sformatf("t1_cnt_k%0d", k));
         expo(K_UEVT, (k == 15 || k == 30 || k == 60) ? 1 : 0, $sformatf("t1_uevt_k%0d", k));
         expo(K_IRQ, 0, $sformatf("t1_irq_k%0d", k));
         expo(K_CMP, 0, $sformatf("t1_cmp_k%0d", k));
         if (k < 20) exprd(A_STATUS, (k >= 15) ? 32'h1F : 32'h0, $sformatf("t1_status_k%0d", k));
         else        exprd(A_ARR, (k >= 22) ? 32'd9 : 32'd4, $sformatf("t1_arr_k%0d", k));
         sync();
      end

      // PWM, interrupt, collisions
      wr(A_CTRL, 0);
      wr(A_PSC, 0);
      wr(A_ARR, 9);
      wr(A_CCR0, 3);
      wr(A_IER, 2);
      wr(A_EGR, 1);
      wr(A_STATUS, 32'h1F);
      wr(A_CTRL, 1);
      for (int k = 1; k <= 30; k++) begin
         if (k == 21)                 wr(A_STATUS, 2);
         else if (k == 22)            wr(A_CNT, 7);
         else if (k == 23 || k == 25) wr(A_STATUS, 1);
         else if (k == 27)            wr(A_CNT, 9);
         else if (k == 28)            wr(A_CNT, 5);
         else                         step(1);
         if (k <= 20) begin
            expo(K_CNT, 32'(k % 10), $sformatf("t3_cnt_k%0d", k));
            expo(K_CMP, (((k - 1) % 10) < 3) ? 1 : 0, $sformatf("t3_cmp_k%0d", k));
            expo(K_UEVT, (k == 10 || k == 20) ? 1 : 0, $sformatf("t3_uevt_k%0d", k));
            expo(K_IRQ, (k >= 3) ? 1 : 0, $sformatf("t3_irq_k%0d", k));
            exprd(A_STATUS, ((k >= 3) ? 32'h2 : 32'h0) | ((k >= 10) ? 32'h1D : 32'h0),
                  $sformatf("t3_status_k%0d", k));
         end else begin
            expo(K_CNT, 32'(t3_cnt[k-21]), $sformatf("t4_cnt_k%0d", k));
            expo(K_CMP, 32'(t3_cmp[k-21]), $sformatf("t4_cmp_k%0d", k));
            expo(K_UEVT, 32'(t3_uevt[k-21]), $sformatf("t4_uevt_k%0d", k));
            expo(K_IRQ, 0, $sformatf("t4_irq_k%0d", k));
            exprd(A_STATUS, 32'(t3_stat[k-21]), $sformatf("t4_status_k%0d", k));
         end
         sync();
      end

      // UG while disabled, then async reset mid-count
      wr(A_CTRL, 0);
      step(2);
      expo(K_CNT, 8, "t5_frozen_cnt");
      expo(K_CMP, 0, "t5_frozen_cmp");
      sync();
      wr(A_STATUS, 32'h1F);
      wr(A_PSC, 5);
      wr(A_EGR, 1);
      expo(K_CNT, 0, "t5_ug_cnt");
      expo(K_UEVT, 1, "t5_ug_uevt");
      expo(K_IRQ, 0, "t5_ug_irq");
      exprd(A_STATUS, 1, "t5_ug_status");
      sync();
      wr(A_IER, 1);
      expo(K_IRQ, 1, "t5_irq_set");
      expo(K_UEVT, 0, "t5_uevt_drop");
      sync();
      wr(A_ARR, 6);
      wr(A_CTRL, 1);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         expo(K_CNT, (k == 6) ? 1 : 0, $sformatf("t5_psc_cnt_k%0d", k));
         expo(K_CMP, 1, $sformatf("t5_cmp_k%0d", k));
         sync();
      end
      step(3);
      #2 reset = 1'b0;
      #1;
      expo(K_CNT, 0, "t5_rst_cnt");
      expo(K_CMP, 0, "t5_rst_cmp");
      expo(K_UEVT, 0, "t5_rst_uevt");
      expo(K_IRQ, 0, "t5_rst_irq");
      exprd(A_ARR, 32'h0000FFFF, "t5_rst_arr");
      sync();
      exprd(A_STATUS, 0, "t5_rst_status");
      sync();
      exprd(A_IER, 0, "t5_rst_ier");
      sync();
      step(1);
      reset = 1'b1;
      step(1);

      // unmapped, write-only and truncated registers
      wr(4'd7, 32'hFFFF_FFFF);
      exprd(4'd7, 0, "unmapped_7");
      sync();
      exprd(A_EGR, 0, "egr_reads_0");
      sync();
      wr(4'd12, 5);
      exprd(4'd12, 0, "unmapped_ccr4");
      sync();
      wr(A_CCR0, 32'h0001_2345);
      exprd(A_CCR0, 32'h2345, "ccr0_trunc");
      sync();
      wr(A_CCR0, 0);

      // one-pulse mode
      wr(A_ARR, 3);
      wr(A_EGR, 1);
      wr(A_CTRL, 3);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         expo(K_UEVT, (k == 4) ? 1 : 0, $sformatf("t6_uevt_k%0d", k));
`ifdef GPTIM_ONE_PULSE_EN
         expo(K_CNT, (k < 4) ? 32'(k) : 32'd0, $sformatf("t6_cnt_k%0d", k));
         exprd(A_CTRL, (k < 4) ? 32'd3 : 32'd2, $sformatf("t6_ctrl_k%0d", k));
`else
         expo(K_CNT, (k < 4) ? 32'(k) : 32'(k - 4), $sformatf("t6_cnt_k%0d", k));
         exprd(A_CTRL, 32'd1, $sformatf("t6_ctrl_k%0d", k));
`endif
         sync();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
